ghostbus_stream_host: RTL



---
 rtl/ghostbus_stream_host.sv | 108 ++++++++++
 1 files changed

// File: rtl/ghostbus_stream_host.sv
// ghostbus_stream_host: byte-stream framed command parser driving single ghostbus write/read cycles
// Frames: opcode, AW/8 address bytes, then DW/8 data bytes for writes; reads answer with DW/8 bytes.
module ghostbus_stream_host #(
  parameter int AW   = 24,
  parameter int DW   = 32,
  parameter int RLAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_din,
  output logic          busy,
  output logic [7:0]    err_count
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WSTB, RSTB, RWAIT, RESP} state_t;
  state_t state_q;
  logic          wr_q, we_q, re_q, txv_q;
  logic [7:0]    cnt_q, err_q;
  logic [3:0]    wait_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dout_q, tx_sh_q;
  logic [AW+7:0] addr_d;
  logic [DW+7:0] dout_d;
  logic          rx_fire, tx_fire;
  assign addr_d    = {addr_q, rx_data};
  assign dout_d    = {dout_q, rx_data};
  assign rx_ready  = !rst && (state_q == IDLE || state_q == ADDR || state_q == WDATA);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = txv_q && tx_ready;
  assign tx_data   = tx_sh_q[DW-1:DW-8];
  assign tx_valid  = txv_q;
  assign gb_addr   = addr_q;
  assign gb_dout   = dout_q;
  assign gb_we     = we_q;
  assign gb_re     = re_q;
  assign busy      = state_q != IDLE;
  assign err_count = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      txv_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      tx_sh_q <= '0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      case (state_q)
        IDLE: if (rx_fire) begin
          cnt_q <= '0;
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            wr_q    <= rx_data == 8'h01;
            state_q <= ADDR;
          end else if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
        ADDR: if (rx_fire) begin
          addr_q <= addr_d[AW-1:0];
          if (cnt_q == 8'(AW/8-1)) begin
            cnt_q   <= '0;
            re_q    <= !wr_q;
            state_q <= wr_q ? WDATA : RSTB;
          end else cnt_q <= cnt_q + 8'd1;
        end
        WDATA: if (rx_fire) begin
          dout_q <= dout_d[DW-1:0];
          if (cnt_q == 8'(DW/8-1)) begin
            we_q    <= 1'b1;
            state_q <= WSTB;
          end else cnt_q <= cnt_q + 8'd1;
        end
        WSTB: state_q <= IDLE;
        RSTB: begin
          wait_q  <= 4'(RLAT-1);
          state_q <= RWAIT;
        end
        RWAIT: if (wait_q == '0) begin
          tx_sh_q <= gb_din;
          txv_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= RESP;
        end else wait_q <= wait_q - 4'd1;
        RESP: if (tx_fire) begin
          tx_sh_q <= tx_sh_q << 8;
          if (cnt_q == 8'(DW/8-1)) begin
            txv_q   <= 1'b0;
            state_q <= IDLE;
          end else cnt_q <= cnt_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
